// File: rtl/regfile_wb_ctrl_if.sv
// Bus bundle for regfile_wb_ctrl: ALU result handshake, load response and
// the register file write port. When REGFILE_WB_PENDING_EN is defined the
// bundle also carries the wb_pending hazard vector.
interface regfile_wb_ctrl_if #(
  parameter int XLEN = 32,
  parameter int AW   = 5
);
  logic            alu_valid;
  logic            alu_ready;
  logic [AW-1:0]   alu_rd;
  logic [XLEN-1:0] alu_data;
  logic            ld_valid;
  logic [AW-1:0]   ld_rd;
  logic [XLEN-1:0] ld_data;
  logic [2:0]      ld_funct3;
  logic [1:0]      ld_byte_off;
  logic            WrEn_RF;
  logic [AW-1:0]   WAddr_RF;
  logic [XLEN-1:0] WD_RF;
`ifdef REGFILE_WB_PENDING_EN
  logic [31:0]     wb_pending;
`endif

  // Producer side: execute/load units and the register file.
  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_valid, ld_rd, ld_data, ld_funct3, ld_byte_off,
    input  alu_ready,
`ifdef REGFILE_WB_PENDING_EN
    input  wb_pending,
`endif
    input  WrEn_RF, WAddr_RF, WD_RF
  );

  // Write-back controller side.
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_valid, ld_rd, ld_data, ld_funct3, ld_byte_off,
    output alu_ready,
`ifdef REGFILE_WB_PENDING_EN
    output wb_pending,
`endif
    output WrEn_RF, WAddr_RF, WD_RF
  );
endinterface

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: single write-port driver for the integer register file.
// Loads always win the port; ALU results queue in a small FIFO behind them
// (or pass straight through when the FIFO is empty). Load data is extended
// here and writes to x0 never reach the register file.
// Optional: define REGFILE_WB_PENDING_EN to add the wb_pending hazard vector.
module regfile_wb_ctrl #(
  parameter int XLEN       = 32,
  parameter int AW         = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic clk,
  input  logic rst_n,
  regfile_wb_ctrl_if.slave bus
);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(FIFO_DEPTH);

  logic [AW-1:0]   fifo_rd_q   [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW:0]     count_q, count_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic            wren_q, wren_d;
  logic [AW-1:0]   waddr_q, waddr_d;
  logic [XLEN-1:0] wd_q, wd_d;
  logic            accept, push, pop;

  // Byte/half extraction and sign/zero extension of an aligned load word.
  function automatic logic [XLEN-1:0] load_extend(input logic [XLEN-1:0] word,
                                                  input logic [2:0] f3,
                                                  input logic [1:0] off);
    logic [XLEN-1:0] sh_b, sh_h;
    logic [7:0]      b;
    logic [15:0]     h;
    sh_b = word >> {off, 3'b000};
    sh_h = word >> {off[1], 4'b0000};
    b    = sh_b[7:0];
    h    = sh_h[15:0];
    case (f3)
      3'b000:  load_extend = {{(XLEN-8){b[7]}}, b};
      3'b100:  load_extend = {{(XLEN-8){1'b0}}, b};
      3'b001:  load_extend = {{(XLEN-16){h[15]}}, h};
      3'b101:  load_extend = {{(XLEN-16){1'b0}}, h};
      default: load_extend = word;
    endcase
  endfunction

  // Readiness depends only on stored occupancy, never on this cycle's inputs.
  assign bus.alu_ready = (count_q < DEPTH_C);
  assign accept        = bus.alu_valid && bus.alu_ready;

  // Arbitration: load first, then FIFO head, then pass-through of the new ALU result.
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    wren_d  = 1'b0;
    waddr_d = waddr_q;
    wd_d    = wd_q;
    if (bus.ld_valid) begin
      wren_d  = (bus.ld_rd != '0);
      waddr_d = bus.ld_rd;
      wd_d    = load_extend(bus.ld_data, bus.ld_funct3, bus.ld_byte_off);
      push    = accept && (bus.alu_rd != '0);
    end else if (count_q != '0) begin
      wren_d  = 1'b1;
      waddr_d = fifo_rd_q[rd_ptr_q];
      wd_d    = fifo_data_q[rd_ptr_q];
      pop     = 1'b1;
      push    = accept && (bus.alu_rd != '0);
    end else if (accept && (bus.alu_rd != '0)) begin
      wren_d  = 1'b1;
      waddr_d = bus.alu_rd;
      wd_d    = bus.alu_data;
    end
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(push);
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; reset drops the queue and any pending write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      wren_q   <= 1'b0;
      waddr_q  <= '0;
      wd_q     <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      wren_q   <= wren_d;
      waddr_q  <= waddr_d;
      wd_q     <= wd_d;
    end
  end

  // FIFO storage; contents are only meaningful below count_q, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_rd_q[wr_ptr_q]   <= bus.alu_rd;
      fifo_data_q[wr_ptr_q] <= bus.alu_data;
    end
  end

  assign bus.WrEn_RF  = wren_q;
  assign bus.WAddr_RF = waddr_q;
  assign bus.WD_RF    = wd_q;

`ifdef REGFILE_WB_PENDING_EN
  logic [31:0] pend;
  logic [PW-1:0] slot_off;

  // Destinations still owed to the register file: live FIFO slots plus the output reg.
  always_comb begin
    pend     = '0;
    slot_off = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      slot_off = PW'(i) - rd_ptr_q;
      if ({1'b0, slot_off} < count_q) pend[fifo_rd_q[i]] = 1'b1;
    end
    if (wren_q) pend[waddr_q] = 1'b1;
    pend[0] = 1'b0;
  end

  assign bus.wb_pending = pend;
`endif
endmodule

// File: tb/tb_regfile_wb_ctrl.sv
module tb_regfile_wb_ctrl;
  localparam int XLEN  = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  regfile_wb_ctrl_if #(.XLEN(XLEN), .AW(AW)) bus ();

  regfile_wb_ctrl #(.XLEN(XLEN), .AW(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference extension straight from the RV32I load definitions.
  function automatic logic [31:0] ext_model(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
    logic [7:0] b;
    logic [15:0] h;
    int bs, hs;
    bs = 8 * int'(off);
    hs = off[1] ? 16 : 0;
    b = 8'((w >> bs) & 32'hFF);
    h = 16'((w >> hs) & 32'hFFFF);
    case (f3)
      3'd0: return {{24{b[7]}}, b};
      3'd4: return {24'd0, b};
      3'd1: return {{16{h[15]}}, h};
      3'd5: return {16'd0, h};
      default: return w;
    endcase
  endfunction

  // Behavioural model: a queue of pending ALU writes behind a load-priority port.
  logic [36:0] mq[$];
  logic        e_wren = 1'b0;
  logic [4:0]  e_addr = '0;
  logic [31:0] e_wd   = '0;

  initial begin : compare_proc
    logic [36:0] ent;
    logic acc;
    logic [31:0] ep;
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        mq.delete();
        e_wren = 1'b0; e_addr = '0; e_wd = '0;
      end else begin
        acc = bus.alu_valid && (mq.size() < DEPTH);
        if (acc && bus.alu_rd != 0) mq.push_back({bus.alu_rd, bus.alu_data});
        if (bus.ld_valid) begin
          e_wren = (bus.ld_rd != 0);
          e_addr = bus.ld_rd;
          e_wd   = ext_model(bus.ld_data, bus.ld_funct3, bus.ld_byte_off);
        end else if (mq.size() > 0) begin
          ent = mq.pop_front();
          e_wren = 1'b1;
          e_addr = ent[36:32];
          e_wd   = ent[31:0];
        end else begin
          e_wren = 1'b0;
        end
      end
      #1;
      chk("model_wren",  32'(bus.WrEn_RF),  32'(e_wren));
      chk("model_waddr", 32'(bus.WAddr_RF), 32'(e_addr));
      chk("model_wd",    bus.WD_RF,         e_wd);
      chk("model_ready", 32'(bus.alu_ready), 32'(mq.size() < DEPTH));
`ifdef REGFILE_WB_PENDING_EN
      ep = '0;
      foreach (mq[k]) ep[mq[k][36:32]] = 1'b1;
      if (e_wren) ep[e_addr] = 1'b1;
      ep[0] = 1'b0;
      chk("model_pending", bus.wb_pending, ep);
`endif
    end
  end

  task automatic idle_inputs();
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.ld_valid = 1'b0; bus.ld_rd = '0; bus.ld_data = '0;
    bus.ld_funct3 = '0; bus.ld_byte_off = '0;
  endtask

  task automatic set_ld(input logic [4:0] rd, input logic [2:0] f3,
                        input logic [1:0] off, input logic [31:0] d);
    bus.ld_valid = 1'b1; bus.ld_rd = rd; bus.ld_funct3 = f3;
    bus.ld_byte_off = off; bus.ld_data = d;
  endtask

  initial begin : stim
    int idx;
    logic prev_rdy, prev_vld;
    logic [4:0] seen[$];
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_wren", 32'(bus.WrEn_RF), 32'd0);
    chk("reset_ready", 32'(bus.alu_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_wren", 32'(bus.WrEn_RF), 32'd0);

    // Single ALU result passes straight through.
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'h1234;
    @(negedge clk);
    idle_inputs();
    chk("alu_wren", 32'(bus.WrEn_RF), 32'd1);
    chk("alu_waddr", 32'(bus.WAddr_RF), 32'd5);
    chk("alu_wd", bus.WD_RF, 32'h1234);

    // Load and ALU in the same cycle: load first, ALU next.
    set_ld(5'd7, 3'b000, 2'd2, 32'h0080_0000);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hAA;
    @(negedge clk);
    idle_inputs();
    chk("lb_waddr", 32'(bus.WAddr_RF), 32'd7);
    chk("lb_wd", bus.WD_RF, 32'hFFFF_FF80);
    @(negedge clk);
    chk("after_ld_waddr", 32'(bus.WAddr_RF), 32'd3);
    chk("after_ld_wd", bus.WD_RF, 32'hAA);
    @(negedge clk);

    // Loads held for 4 cycles fill the FIFO; ALU results must drain in order.
    idx = 0; prev_rdy = 1'b0; prev_vld = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (prev_vld && prev_rdy) idx++;
      if (bus.WrEn_RF && bus.WAddr_RF != 5'd10) seen.push_back(bus.WAddr_RF);
      if (k == 2) chk("bp_ready_low", 32'(bus.alu_ready), 32'd0);
      if (k < 4) set_ld(5'd10, 3'b010, 2'd0, 32'(k));
      else begin bus.ld_valid = 1'b0; bus.ld_rd = '0; end
      bus.alu_valid = (idx < 3);
      bus.alu_rd = 5'(idx + 1);
      bus.alu_data = 32'h100 + 32'(idx);
      prev_vld = bus.alu_valid;
      prev_rdy = bus.alu_ready;
      @(negedge clk);
    end
    idle_inputs();
    chk("bp_count", 32'(seen.size()), 32'd3);
    for (int k = 0; k < 3; k++)
      chk("bp_order", (k < seen.size()) ? 32'(seen[k]) : 32'hFFFF_FFFF, 32'(k + 1));

    // Halfword/word extension.
    set_ld(5'd4, 3'b101, 2'd2, 32'hBEEF_0000);
    @(negedge clk);
    chk("lhu_wd", bus.WD_RF, 32'h0000_BEEF);
    set_ld(5'd4, 3'b001, 2'd2, 32'hBEEF_0000);
    @(negedge clk);
    chk("lh_wd", bus.WD_RF, 32'hFFFF_BEEF);
    set_ld(5'd4, 3'b010, 2'd2, 32'hBEEF_0000);
    @(negedge clk);
    chk("lw_wd", bus.WD_RF, 32'hBEEF_0000);
    idle_inputs();
    @(negedge clk);

    // x0 writes are suppressed from both sources.
    set_ld(5'd0, 3'b010, 2'd0, 32'hDEAD_BEEF);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
    @(negedge clk);
    idle_inputs();
    chk("x0_wren_1", 32'(bus.WrEn_RF), 32'd0);
    @(negedge clk);
    chk("x0_wren_2", 32'(bus.WrEn_RF), 32'd0);

`ifdef REGFILE_WB_PENDING_EN
    set_ld(5'd11, 3'b010, 2'd0, 32'h1);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd9; bus.alu_data = 32'h99;
    @(negedge clk);
    idle_inputs();
    chk("pend_bit9_queued", 32'(bus.wb_pending[9]), 32'd1);
    chk("pend_bit0", 32'(bus.wb_pending[0]), 32'd0);
    @(negedge clk);
    chk("pend_bit9_writing", 32'(bus.wb_pending[9]), 32'd1);
    @(negedge clk);
    chk("pend_bit9_done", 32'(bus.wb_pending[9]), 32'd0);
`endif

    // Randomized traffic with a mid-run reset pulse.
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) begin
        rst_n = 1'b0;
        #1;
        chk("midrst_wren", 32'(bus.WrEn_RF), 32'd0);
        chk("midrst_waddr", 32'(bus.WAddr_RF), 32'd0);
        chk("midrst_wd", bus.WD_RF, 32'd0);
        chk("midrst_ready", 32'(bus.alu_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
      end
      bus.ld_valid = ($urandom_range(0, 99) < ((c / 200) % 2 == 0 ? 25 : 70));
      bus.ld_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      bus.ld_data = $urandom;
      bus.ld_funct3 = 3'($urandom);
      bus.ld_byte_off = 2'($urandom);
      bus.alu_valid = ($urandom_range(0, 99) < 60);
      bus.alu_rd = ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom);
      bus.alu_data = $urandom;
      @(negedge clk);
    end
    idle_inputs();
    repeat (4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/regfile_wb_ctrl.md
Name: regfile_wb_ctrl

Overview:
- Write-port driver for the 32x32 integer register file; it owns WrEn_RF, WAddr_RF and WD_RF.
- Merges ALU results and load-unit responses into the single register file write port.
- Loads have fixed priority. ALU results are buffered in a small FIFO with valid/ready backpressure.
- Load data is byte/half extended here. Writes to x0 are suppressed here, so the register file never sees them.

Parameters:
XLEN, 32, data width of results and WD_RF
AW, 5, register address width
FIFO_DEPTH, 2, ALU result buffer entries (power of two, >=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
alu_valid  input  1  ALU result offered
alu_ready  output  1  ALU result accepted when alu_valid && alu_ready
alu_rd  input  AW  ALU destination register
alu_data  input  XLEN  ALU result
ld_valid  input  1  load response; never backpressured
ld_rd  input  AW  load destination register
ld_data  input  XLEN  raw aligned memory word
ld_funct3  input  3  load type (RV32I encoding)
ld_byte_off  input  2  address[1:0] of the load
WrEn_RF  output  1  register file write enable (registered)
WAddr_RF  output  AW  register file write address (registered)
WD_RF  output  XLEN  register file write data (registered)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- While rst_n is low: WrEn_RF=0, WAddr_RF=0, WD_RF=0, FIFO emptied, alu_ready=1. Any write in flight is dropped.
- alu_ready = (FIFO count < FIFO_DEPTH). It is registered-state only, with no combinational path from alu_valid or ld_valid.
- ALU accept with alu_rd==0 is acknowledged and discarded; it is never enqueued.
- ALU candidate each cycle: the FIFO head if the FIFO is non-empty. Otherwise it is the incoming accepted ALU result (pass-through).
- Arbitration each cycle:
  - ld_valid wins. The output regs load the extended load data and ld_rd. WrEn_RF is set to (ld_rd!=0).
  - An incoming accepted ALU result that is not written this cycle is enqueued at the tail.
  - If ld_valid is low and an ALU candidate exists, the output regs take the candidate and WrEn_RF=1. The head is popped if the candidate came from the FIFO.
  - Accepting and popping in the same cycle is legal; count is unchanged.
  - Otherwise WrEn_RF=0; WAddr_RF and WD_RF hold their values.
- Latency:
  - Accept/response in cycle N gives WrEn_RF high in cycle N+1 when not blocked.
  - Each blocking load adds 1 cycle.
  - ALU results are written strictly in acceptance order.
- Full FIFO with ld_valid held high: alu_ready=0 until a slot frees. There is no overflow and no drop.
- Load extension (shift = 8*ld_byte_off):
  - 000 lb: sign-extend byte.
  - 100 lbu: zero-extend byte.
  - 001 lh: sign-extend half at ld_byte_off[1].
  - 101 lhu: zero-extend half at ld_byte_off[1].
  - 010 lw and all other codes: full word.
  - ld_byte_off[0] is ignored for halves. ld_byte_off is ignored for words.
- Ordering between a load and an ALU result to the same rd is the issue stage's responsibility. This block does not reorder or cancel.
- Pointers wrap modulo FIFO_DEPTH. Count is in the range 0..FIFO_DEPTH.

Optional Feature:
- Macro REGFILE_WB_PENDING_EN.
- Defined: extra output wb_pending [31:0]. Bit i=1 when any valid FIFO entry or the current output reg (WrEn_RF=1) targets register i. Bit 0 is always 0. The output is combinational from internal state only, for hazard stall logic.
- Undefined: the port and its logic are absent. Behaviour is otherwise identical.

Test Plan:
- Reset then idle -> WrEn_RF=0, alu_ready=1. Pulse rst_n low mid-traffic -> outputs 0 that cycle and the FIFO empties.
- alu_valid, rd=5, data=0x1234 at cycle N, no load -> WrEn_RF=1, WAddr_RF=5, WD_RF=0x1234 at N+1.
- Same cycle: ld rd=7, lb, off=2, ld_data=0x00800000; alu rd=3 data=0xAA -> N+1 writes x7=0xFFFFFF80, N+2 writes x3=0xAA.
- ld_valid held 4 cycles while alu_valid offers rd=1,2,3 -> alu_ready falls after 2 accepts. After the loads, writes x1, x2, x3 in order; no loss.
- lhu off=2 ld_data=0xBEEF0000 -> 0x0000BEEF. lh same -> 0xFFFFBEEF. lw -> 0xBEEF0000.
- alu rd=0 and ld rd=0 -> WrEn_RF stays 0. With REGFILE_WB_PENDING_EN, bit 0 is 0 and the bit for a queued rd=9 is 1 until written.
